branch_stat_unit: RTL and testbench
===================================

# branch_stat_unit

Counts control-flow events reported by the pipelined datapath's `stat_*` outputs (beq/bne/blt/bge/bltu/bgeu/jal/jalr in EX, pipeline flushes) plus enabled cycles. It sits directly downstream of the datapath and consumes its statistics outputs. A 4-phase snapshot handshake atomically copies all live counters into a shadow bank. A registered read port returns shadow values to a debug/host reader, so the core never stalls for readout.

## Interface
Parameters:
- `CNT_W`, default 32: width of every counter.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: count enable; events and cycles are counted only when high.
- `clr`  in  1: synchronous clear pulse for live counters and `ovf`.
- `stat_beq`, `stat_bne`, `stat_blt`, `stat_bge`, `stat_bltu`, `stat_bgeu`, `stat_jal`, `stat_jalr`, `stat_PL_flush`  in  1 each: event inputs from the datapath.
- `snap_req`  in  1: snapshot request, level, held until `snap_ack`.
- `snap_ack`  out  1: snapshot complete, held while `snap_req` stays high.
- `rd_req`  in  1: read strobe.
- `rd_sel`  in  4: counter index.
- `rd_valid`  out  1: pulses one cycle after `rd_req`.
- `rd_data`  out  CNT_W: shadow value of the selected counter.
- `ovf`  out  11: sticky per-counter overflow flags, live bank.

## Operation
- Counter indices:
  - 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu, 6 jal, 7 jalr.
  - 8 flush.
  - 9 cycles: +1 every cycle with `en`=1.
  - 10 branch_total: +1 when any of indices 0–5 is asserted.
  - 11–15: reserved, read 0.
- Each asserted input adds exactly 1 per cycle. No edge detection: a signal held high N cycles counts N.
- Priority per counter: `rst` > `clr` > increment. An increment coincident with `clr` is lost and the counter becomes 0.
- Overflow: an increment while the counter is all-ones sets the matching `ovf` bit. The wrap/saturate result is per Configuration. `ovf` is cleared only by `rst` or `clr`.
- Snapshot FSM, states IDLE, SNAP, DONE:
  - IDLE → SNAP when `snap_req`=1.
  - SNAP → DONE unconditionally. On this edge, shadow ← current live register values. Same-cycle increments and clear are excluded: `clr` in the SNAP cycle still yields pre-clear values in shadow.
  - DONE: `snap_ack`=1. DONE → IDLE when `snap_req`=0.
  - `snap_req` dropping while in SNAP is ignored; the snapshot completes.
- Read port:
  - `rd_req`=1 registers `rd_data` ← shadow[`rd_sel`] and sets `rd_valid`=1 next cycle. Otherwise `rd_valid`=0 and `rd_data` holds its value.
  - Reads are allowed in any FSM state. A read issued in the SNAP cycle returns the pre-snapshot shadow.
- Live counters are never directly readable. `clr` does not affect the shadow bank.

## Timing
- Reset values: all live counters, shadow, and `ovf` = 0; FSM = IDLE; `snap_ack`=0; `rd_valid`=0; `rd_data`=0.
- Event at edge k is visible in the live counter after edge k.
- `snap_req` rising before edge k: SNAP after k, `snap_ack`=1 after k+1. Minimum 2 cycles request→ack.
- Read latency: 1 cycle, fully pipelined; back-to-back `rd_req` allowed every cycle.
- `rst` mid-snapshot returns the FSM to IDLE and drops `snap_ack` the next cycle.

## Configuration
- `BRSTAT_SATURATE_EN` defined: counters stick at all-ones on overflow.
- Undefined: counters wrap to 0.
- `ovf` behaves identically in both builds.

## Structure
- Package `brstat_pkg` holds:
  - `NUM_CNT`=11.
  - Index constants `BRSTAT_IDX_BEQ` … `BRSTAT_IDX_TOTAL`.
  - FSM state enum `brstat_state_t` (IDLE/SNAP/DONE).
- Sub-module `brstat_counter`: one CNT_W counter with `inc`/`clr`, overflow output, and the saturate option; instantiated 11 times.
- Top level holds the event decode, shadow bank, FSM, and read mux.

## Test plan
- Reset: assert `rst` 2 cycles, snapshot, read indices 0–15 → all `rd_data`=0, `ovf`=0, `snap_ack` low until requested.
- Basic count: `en`=1, `stat_beq`=1 for 5 cycles, `stat_bltu`=1 for 2 cycles, idle 3 cycles, snapshot. Required reads:
  - idx0 = 5, idx4 = 2, idx10 = 7.
  - idx9 = total enabled cycles.
- Enable/clear: `en`=0 with `stat_jal`=1 for 4 cycles → idx6 = 0. Then `en`=1, `stat_bne` high with `clr` in the same cycle → idx1 = 0.
- Snapshot atomicity: `stat_jalr`=1 continuously, request snapshot. After ack, read idx7 = live value at the SNAP edge. Assert `clr` in the SNAP cycle → shadow still pre-clear.
- Overflow, `CNT_W`=4: 17 `stat_PL_flush` pulses → idx8 = 15 with `BRSTAT_SATURATE_EN`, 1 without; `ovf[8]`=1 in both builds.
- Read pipelining: `rd_req` on 3 consecutive cycles with `rd_sel`=0,1,15 → three consecutive `rd_valid` pulses returning shadow0, shadow1, 0.

Source files
------------

// File: rtl/brstat_pkg.sv
// rtl/brstat_pkg.sv - shared constants and FSM state type for the branch statistics unit
package brstat_pkg;
    localparam int NUM_CNT = 11;

    localparam int BRSTAT_IDX_BEQ    = 0;
    localparam int BRSTAT_IDX_BNE    = 1;
    localparam int BRSTAT_IDX_BLT    = 2;
    localparam int BRSTAT_IDX_BGE    = 3;
    localparam int BRSTAT_IDX_BLTU   = 4;
    localparam int BRSTAT_IDX_BGEU   = 5;
    localparam int BRSTAT_IDX_JAL    = 6;
    localparam int BRSTAT_IDX_JALR   = 7;
    localparam int BRSTAT_IDX_FLUSH  = 8;
    localparam int BRSTAT_IDX_CYCLES = 9;
    localparam int BRSTAT_IDX_TOTAL  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        DONE = 2'd2
    } brstat_state_t;
endpackage

// File: rtl/brstat_counter.sv
// rtl/brstat_counter.sv - one event counter with clear, sticky overflow, optional saturation (BRSTAT_SATURATE_EN)
module brstat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc) begin
            if (w_full) begin
                r_ovf <= 1'b1;
`ifdef BRSTAT_SATURATE_EN
                r_cnt <= r_cnt;
`else
                r_cnt <= '0;
`endif
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/branch_stat_unit.sv
// rtl/branch_stat_unit.sv - control-flow event counters with snapshot shadow bank and registered read port
module branch_stat_unit
    import brstat_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             stat_beq,
    input  logic             stat_bne,
    input  logic             stat_blt,
    input  logic             stat_bge,
    input  logic             stat_bltu,
    input  logic             stat_bgeu,
    input  logic             stat_jal,
    input  logic             stat_jalr,
    input  logic             stat_PL_flush,
    input  logic             snap_req,
    output logic             snap_ack,
    input  logic             rd_req,
    input  logic [3:0]       rd_sel,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic [10:0]      ovf
);
    logic [NUM_CNT-1:0] w_inc;
    logic [NUM_CNT-1:0] w_ovf;
    logic [5:0]         w_branch;
    logic [CNT_W-1:0]   w_live   [NUM_CNT];
    logic [CNT_W-1:0]   r_shadow [NUM_CNT];
    logic [CNT_W-1:0]   w_rd_mux;
    brstat_state_t      r_state;
    logic               r_snap_ack;
    logic               r_rd_valid;
    logic [CNT_W-1:0]   r_rd_data;

    assign w_branch = {stat_bgeu, stat_bltu, stat_bge, stat_blt, stat_bne, stat_beq};

    assign w_inc[BRSTAT_IDX_BEQ]    = en & stat_beq;
    assign w_inc[BRSTAT_IDX_BNE]    = en & stat_bne;
    assign w_inc[BRSTAT_IDX_BLT]    = en & stat_blt;
    assign w_inc[BRSTAT_IDX_BGE]    = en & stat_bge;
    assign w_inc[BRSTAT_IDX_BLTU]   = en & stat_bltu;
    assign w_inc[BRSTAT_IDX_BGEU]   = en & stat_bgeu;
    assign w_inc[BRSTAT_IDX_JAL]    = en & stat_jal;
    assign w_inc[BRSTAT_IDX_JALR]   = en & stat_jalr;
    assign w_inc[BRSTAT_IDX_FLUSH]  = en & stat_PL_flush;
    assign w_inc[BRSTAT_IDX_CYCLES] = en;
    assign w_inc[BRSTAT_IDX_TOTAL]  = en & (|w_branch);

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        brstat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .i_inc (w_inc[gi]),
            .i_clr (clr),
            .o_cnt (w_live[gi]),
            .o_ovf (w_ovf[gi])
        );
    end

    // Shadow is loaded on the SNAP->DONE edge from pre-edge live values,
    // so a same-cycle clear or increment never leaks into the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_snap_ack <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (snap_req) begin
                        r_state <= SNAP;
                    end
                end
                SNAP: begin
                    r_state    <= DONE;
                    r_snap_ack <= 1'b1;
                    for (int i = 0; i < NUM_CNT; i++) begin
                        r_shadow[i] <= w_live[i];
                    end
                end
                DONE: begin
                    if (!snap_req) begin
                        r_state    <= IDLE;
                        r_snap_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_snap_ack <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (rd_sel < 4'(NUM_CNT)) begin
            w_rd_mux = r_shadow[rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign snap_ack = r_snap_ack;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign ovf      = w_ovf;
endmodule

// File: tb/tb_branch_stat_unit.sv
// tb/tb_branch_stat_unit.sv - scoreboard bench for branch_stat_unit (CNT_W=4 to reach overflow quickly)
module tb_branch_stat_unit;
    localparam int W = 4;
`ifdef BRSTAT_SATURATE_EN
    localparam logic [W-1:0] EXP_FLUSH_OVF = 4'd15;
    localparam logic [W-1:0] EXP_CYC_OVF   = 4'd15;
`else
    localparam logic [W-1:0] EXP_FLUSH_OVF = 4'd1;
    localparam logic [W-1:0] EXP_CYC_OVF   = 4'd2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, clr = 1'b0;
    logic         beq = 1'b0, bne = 1'b0, blt = 1'b0, bge = 1'b0, bltu = 1'b0, bgeu = 1'b0;
    logic         jal = 1'b0, jalr = 1'b0, flush = 1'b0;
    logic         snap_req = 1'b0, rd_req = 1'b0;
    logic [3:0]   rd_sel = 4'd0;
    logic         snap_ack, rd_valid;
    logic [W-1:0] rd_data;
    logic [10:0]  ovf;

    int           n_pass = 0;
    int           n_total = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic         prev_req = 1'b0;

    branch_stat_unit #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .stat_beq(beq), .stat_bne(bne), .stat_blt(blt), .stat_bge(bge),
        .stat_bltu(bltu), .stat_bgeu(bgeu), .stat_jal(jal), .stat_jalr(jalr),
        .stat_PL_flush(flush),
        .snap_req(snap_req), .snap_ack(snap_ack),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int sel, input logic [W-1:0] exp);
        rd_req = 1'b1;
        rd_sel = 4'(sel);
        exp_q.push_back(exp);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic snapshot(input bit clr_in_snap);
        snap_req = 1'b1;
        tick();
        chk("snap_ack_early", {31'd0, snap_ack}, 32'd0);
        if (clr_in_snap) clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("snap_ack_set", {31'd0, snap_ack}, 32'd1);
        tick();
        chk("snap_ack_hold", {31'd0, snap_ack}, 32'd1);
        snap_req = 1'b0;
        tick();
        chk("snap_ack_drop", {31'd0, snap_ack}, 32'd0);
    endtask

    // Read monitor: rd_valid must follow rd_req by exactly one cycle.
    always @(negedge clk) begin
        if (!rst && (rd_valid || prev_req)) begin
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, prev_req});
            if (prev_req) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rd_queue: got empty queue expected an entry");
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (rd_valid) chk("rd_data", {28'd0, rd_data}, {28'd0, mon_exp});
                end
            end
        end
        prev_req = rd_req;
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ovf", {21'd0, ovf}, 32'd0);
        chk("rst_ack", {31'd0, snap_ack}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {28'd0, rd_data}, 32'd0);
        snapshot(1'b0);
        for (int i = 0; i < 16; i++) rd(i, '0);
        tick();

        // basic counting
        en = 1'b1; beq = 1'b1;
        repeat (5) tick();
        beq = 1'b0; bltu = 1'b1;
        repeat (2) tick();
        bltu = 1'b0;
        repeat (3) tick();
        en = 1'b0;
        snapshot(1'b0);
        rd(0, 4'd5); rd(4, 4'd2); rd(10, 4'd7); rd(9, 4'd10); rd(1, 4'd0);
        tick();

        // enable gating and clear priority
        jal = 1'b1;
        repeat (4) tick();
        jal = 1'b0;
        en = 1'b1; bne = 1'b1; clr = 1'b1;
        tick();
        en = 1'b0; bne = 1'b0; clr = 1'b0;
        snapshot(1'b0);
        rd(6, 4'd0); rd(1, 4'd0); rd(0, 4'd0); rd(9, 4'd0);
        tick();

        // snapshot atomicity with a continuously asserted event
        en = 1'b1; jalr = 1'b1;
        repeat (3) tick();
        snap_req = 1'b1;
        tick();
        chk("atom_ack_early", {31'd0, snap_ack}, 32'd0);
        tick();
        chk("atom_ack", {31'd0, snap_ack}, 32'd1);
        snap_req = 1'b0; jalr = 1'b0; en = 1'b0;
        tick();
        chk("atom_ack_drop", {31'd0, snap_ack}, 32'd0);
        rd(7, 4'd4); rd(9, 4'd4); rd(10, 4'd0);
        tick();
        snapshot(1'b1);
        rd(7, 4'd5); rd(9, 4'd5);
        tick();

        // counts after the in-SNAP clear, plus back-to-back reads
        en = 1'b1; beq = 1'b1;
        repeat (3) tick();
        beq = 1'b0; bne = 1'b1;
        repeat (2) tick();
        bne = 1'b0; en = 1'b0;
        snapshot(1'b0);
        rd(0, 4'd3); rd(1, 4'd2); rd(15, 4'd0);
        tick();
        rd(7, 4'd0); rd(10, 4'd5); rd(9, 4'd5);
        tick();

        // overflow of the 4-bit flush and cycle counters
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", {21'd0, ovf}, 32'd0);
        en = 1'b1;
        repeat (15) begin
            flush = 1'b1; tick();
            flush = 1'b0; tick();
        end
        chk("ovf8_at_max", {31'd0, ovf[8]}, 32'd0);
        chk("ovf9_set", {31'd0, ovf[9]}, 32'd1);
        repeat (2) begin
            flush = 1'b1; tick();
            flush = 1'b0; tick();
        end
        en = 1'b0;
        chk("ovf8_set", {31'd0, ovf[8]}, 32'd1);
        chk("ovf0_clear", {31'd0, ovf[0]}, 32'd0);
        snapshot(1'b0);
        rd(8, EXP_FLUSH_OVF); rd(9, EXP_CYC_OVF);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_cleared", {21'd0, ovf}, 32'd0);
        rd(8, EXP_FLUSH_OVF);
        tick();
        tick();

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL rd_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
